tick_timer: RTL and testbench

TICK_TIMER -- requirements
Module: tick_timer

---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_count.sv | 25 ++
 rtl/tick_timer.sv | 114 +++++++++++
 tb/tb_tick_timer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and default period for tick_timer
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // One second at a 12 MHz reference clock
  localparam int unsigned TIMER_DEFAULT_PERIOD = 12_000_000;

endpackage

// File: rtl/timer_count.sv
// rtl/timer_count.sv - counter incrementer and terminal-count comparator
module timer_count #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count_inc,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] last;
  logic             borrow;
  logic [WIDTH-1:0] unused_diff;

  // A zero period behaves as one, so the last count value is 0 in both cases
  assign last = (period == '0) ? '0 : period - ONE;

  // No borrow means count >= last; a count can never run past the terminal value
  assign {borrow, unused_diff} = {1'b0, count} - {1'b0, last};
  assign terminal  = ~borrow;
  assign count_inc = count + ONE;

endmodule

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - programmable periodic/one-shot tick timer (option: TICK_TIMER_PRESCALE_EN)
module tick_timer
  import timer_pkg::*;
#(
  parameter int          WIDTH          = 24,
  parameter int unsigned DEFAULT_PERIOD = TIMER_DEFAULT_PERIOD
`ifdef TICK_TIMER_PRESCALE_EN
  ,
  parameter int          PRESCALE       = 1
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  input  logic             oneshot_in,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] cfg_period;
  logic             cfg_oneshot;
  logic             tick_n;
  logic             terminal;
  logic             advance;

  assign busy = (state != IDLE);

  timer_count #(.WIDTH(WIDTH)) u_count (
    .count    (count),
    .period   (cfg_period),
    .count_inc(count_inc),
    .terminal (terminal)
  );

`ifdef TICK_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;
  logic          presc_wrap;

  assign presc_wrap = (presc == PW'(PRESCALE - 1));
  assign advance    = presc_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (start || stop || load || !busy) begin
      presc <= '0;
    end else if (enable) begin
      presc <= presc_wrap ? '0 : presc + PW'(1);
    end
  end
`else
  assign advance = 1'b1;
`endif

  // Priority: stop, then start, then load restart, then hold/expiry
  always_comb begin
    state_n = state;
    count_n = count;
    tick_n  = 1'b0;
    if (stop) begin
      state_n = IDLE;
      count_n = '0;
    end else if (start) begin
      state_n = RUN;
      count_n = '0;
    end else if (state != IDLE) begin
      if (load) begin
        count_n = '0;
      end else if (!enable) begin
        state_n = HOLD;
      end else begin
        state_n = RUN;
        if (advance) begin
          if (terminal) begin
            count_n = '0;
            tick_n  = 1'b1;
            if (cfg_oneshot) state_n = IDLE;
          end else begin
            count_n = count_inc;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      count       <= '0;
      tick        <= 1'b0;
      cfg_period  <= WIDTH'(DEFAULT_PERIOD);
      cfg_oneshot <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      tick  <= tick_n;
      if (load) begin
        cfg_period  <= period_in;
        cfg_oneshot <= oneshot_in;
      end
    end
  end

endmodule

// File: tb/tb_tick_timer.sv
// tb/tb_tick_timer.sv - directed self-checking bench for tick_timer
module tb_tick_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, enable, load, oneshot_in;
  logic [23:0] period_in;
  logic        tick, busy;
  logic [23:0] count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

`ifdef TICK_TIMER_PRESCALE_EN
  logic        tick2, busy2;
  logic [23:0] count2;

  tick_timer #(.WIDTH(24), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .enable(enable), .load(load),
    .period_in(period_in), .oneshot_in(oneshot_in), .tick(tick), .busy(busy), .count(count)
  );

  tick_timer #(.WIDTH(24), .PRESCALE(3)) dut_ps (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .enable(enable), .load(load),
    .period_in(period_in), .oneshot_in(oneshot_in), .tick(tick2), .busy(busy2), .count(count2)
  );
`else
  tick_timer #(.WIDTH(24)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .enable(enable), .load(load),
    .period_in(period_in), .oneshot_in(oneshot_in), .tick(tick), .busy(busy), .count(count)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic steps(input int n, output int nticks);
    nticks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tick) nticks++;
    end
  endtask

  // Returns the number of edges until tick is seen (-1 if none within max)
  task automatic wait_tick(input int max, output int k, output logic [31:0] prev);
    k    = -1;
    prev = '0;
    for (int i = 1; i <= max; i++) begin
      prev = {8'd0, count};
      @(negedge clk);
      if (tick) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic do_load(input logic [23:0] p, input logic os);
    period_in  = p;
    oneshot_in = os;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  int          k, nt;
  logic [31:0] prev;

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; enable = 1'b1; load = 1'b0;
    oneshot_in = 1'b0; period_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_count", {8'd0, count}, 0);
    chk("rst_tick", {31'd0, tick}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 1'b1;

    // Default period is long: 30 cycles counts up with no tick
    pulse_start();
    chk("dflt_busy", {31'd0, busy}, 1);
    steps(30, nt);
    chk("dflt_noticks", nt, 0);
    chk("dflt_count", {8'd0, count}, 30);
    pulse_stop();

    // Periodic P=22: ticks at 22, 44, 66 edges after start, count wraps 21->0
    do_load(24'd22, 1'b0);
    pulse_start();
    wait_tick(40, k, prev);
    chk("p22_first", k, 22);
    chk("p22_prev", prev, 21);
    chk("p22_wrap", {8'd0, count}, 0);
    wait_tick(40, k, prev);
    chk("p22_second", k, 22);
    wait_tick(40, k, prev);
    chk("p22_third", k, 22);
    pulse_stop();

    // One-shot P=5: single tick, busy drops with it
    do_load(24'd5, 1'b1);
    pulse_start();
    wait_tick(20, k, prev);
    chk("os_tick", k, 5);
    chk("os_busy", {31'd0, busy}, 0);
    chk("os_count", {8'd0, count}, 0);
    steps(20, nt);
    chk("os_noticks", nt, 0);

    // P=10 with 7 held cycles from cycle 3: first tick at 17
    do_load(24'd10, 1'b0);
    pulse_start();
    steps(3, nt);
    chk("hold_pre", {8'd0, count}, 3);
    enable = 1'b0;
    steps(7, nt);
    chk("hold_count", {8'd0, count}, 3);
    chk("hold_busy", {31'd0, busy}, 1);
    chk("hold_noticks", nt, 0);
    enable = 1'b1;
    wait_tick(20, k, prev);
    chk("hold_first", k + 10, 17);
    pulse_stop();

    // P=8, stop on the expiry edge suppresses the tick
    do_load(24'd8, 1'b0);
    pulse_start();
    steps(7, nt);
    chk("stopx_pre", {8'd0, count}, 7);
    pulse_stop();
    chk("stopx_tick", {31'd0, tick}, 0);
    chk("stopx_busy", {31'd0, busy}, 0);
    chk("stopx_count", {8'd0, count}, 0);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", {31'd0, busy}, 0);
    steps(3, nt);
    chk("ss_count", {8'd0, count}, 0);

    // P=0 ticks every RUN cycle; reload P=4 at cycle 2
    do_load(24'd0, 1'b0);
    pulse_start();
    steps(2, nt);
    chk("p0_ticks", nt, 2);
    do_load(24'd4, 1'b0);
    wait_tick(10, k, prev);
    chk("p4_after_load", k, 4);
    wait_tick(10, k, prev);
    chk("p4_period", k, 4);
    pulse_stop();

    // Reset mid-period clears outputs without waiting for a clock edge
    do_load(24'd22, 1'b0);
    pulse_start();
    steps(15, nt);
    chk("rmid_pre", {8'd0, count}, 15);
    #2 rst = 1'b0;
    #1;
    chk("rmid_count", {8'd0, count}, 0);
    chk("rmid_busy", {31'd0, busy}, 0);
    chk("rmid_tick", {31'd0, tick}, 0);
    @(negedge clk);
    rst = 1'b1;
    steps(40, nt);
    chk("rmid_noticks", nt, 0);
    chk("rmid_idle", {31'd0, busy}, 0);

`ifdef TICK_TIMER_PRESCALE_EN
    // PRESCALE=3, P=4: one tick every 12 cycles
    do_load(24'd4, 1'b0);
    pulse_start();
    k = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (tick2) begin
        k = i;
        break;
      end
    end
    chk("ps_first", k, 12);
    k = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (tick2) begin
        k = i;
        break;
      end
    end
    chk("ps_period", k, 12);
    pulse_stop();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
